// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths and fetch state encoding.
package cpu_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INST_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction-memory address, tracks the
// address of the instruction currently returned, and handles stall/redirect/halt.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              halt,
  input  logic [INST_W-1:0] mem_inst,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  output logic              done
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_n, inst_pc_n;
  logic            inst_valid_n, done_n;

  // Memory data is already registered, so the instruction is a straight pass-through.
  assign inst = mem_inst;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid;
    done_n       = done;
    case (state)
      IDLE, HALTED: begin
        inst_valid_n = 1'b0;
        if (start) begin
          state_n = FETCH;
          pc_n    = START_PC;
          done_n  = 1'b0;
        end
      end
      FETCH: begin
        if (halt) begin
          state_n      = HALTED;
          inst_valid_n = 1'b0;
          done_n       = 1'b1;
        end else if (br_taken) begin
          // Data returning next cycle belongs to the wrong path; drop it.
          pc_n         = br_target;
          inst_valid_n = 1'b0;
        end else if (!stall) begin
          inst_pc_n    = pc;
          pc_n         = pc + PC_W'(1);
          inst_valid_n = 1'b1;
        end
      end
      default: begin
        state_n      = IDLE;
        inst_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random stimulus
// against a behavioural fetch model and a registered instruction memory.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  localparam logic [7:0] START = 8'h00;
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b10000;
  localparam logic [4:0] C_START = 5'b01000;
  localparam logic [4:0] C_STALL = 5'b00100;
  localparam logic [4:0] C_BR    = 5'b00010;
  localparam logic [4:0] C_HALT  = 5'b00001;

  logic       clk = 1'b0;
  logic       reset, start, stall, br_taken, halt;
  logic [7:0] br_target;
  logic [8:0] mem_inst;
  logic [7:0] pc, inst_pc;
  logic [8:0] inst;
  logic       inst_valid, done;

  logic [8:0] mem [256];

  bit         m_run, m_done, m_valid, m_seen_reset;
  logic [7:0] m_pc, m_ipc;
  logic [8:0] m_inst;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // External synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) mem_inst <= mem[pc];

  fetch_ctrl #(.START_PC(START)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .mem_inst(mem_inst), .pc(pc), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: apply controls, advance the model on the edge, compare after it.
  task automatic step(input logic [4:0] c, input logic [7:0] tgt);
    bit inst_ok;
    {reset, start, stall, br_taken, halt} = c;
    br_target = tgt;
    @(posedge clk);
    inst_ok = m_seen_reset;
    m_inst  = mem[m_pc];
    if (c[4]) begin
      m_run = 0; m_done = 0; m_valid = 0; m_pc = 8'h00; m_ipc = 8'h00;
      m_seen_reset = 1;
    end else if (!m_run) begin
      m_valid = 0;
      if (c[3]) begin
        m_run = 1; m_pc = START; m_done = 0;
      end
    end else if (c[0]) begin
      m_run = 0; m_valid = 0; m_done = 1;
    end else if (c[1]) begin
      m_pc = tgt; m_valid = 0;
    end else if (!c[2]) begin
      m_ipc = m_pc; m_pc = m_pc + 8'd1; m_valid = 1;
    end
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("done", 32'(done), 32'(m_done));
    if (inst_ok) chk("inst", 32'(inst), 32'(m_inst));
  endtask

  initial begin
    logic [4:0] c;
    for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
    m_pc = 8'h00; m_ipc = 8'h00;
    {reset, start, stall, br_taken, halt} = C_NONE;
    br_target = 8'h00;

    step(C_RST, 8'h00);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    step(C_NONE, 8'h00);
    chk("no_start_pc", 32'(pc), 32'h00);

    // Straight-line fetch from START_PC.
    step(C_START, 8'h00);
    chk("start_pc", 32'(pc), 32'h00);
    chk("start_valid", 32'(inst_valid), 32'h0);
    step(C_NONE, 8'h00);
    chk("first_valid", 32'(inst_valid), 32'h1);
    chk("first_ipc", 32'(inst_pc), 32'h00);
    chk("first_inst", 32'(inst), 32'(mem[0]));
    step(C_NONE, 8'h00);
    step(C_NONE, 8'h00);
    chk("pc_3", 32'(pc), 32'h03);
    for (int i = 0; i < 3; i++) step(C_NONE, 8'h00);
    chk("pre_stall_ipc", 32'(inst_pc), 32'h05);

    // Stall holds everything, release advances.
    for (int i = 0; i < 3; i++) begin
      step(C_STALL, 8'h00);
      chk("stall_pc", 32'(pc), 32'h06);
      chk("stall_ipc", 32'(inst_pc), 32'h05);
      chk("stall_valid", 32'(inst_valid), 32'h1);
    end
    step(C_NONE, 8'h00);
    chk("release_ipc", 32'(inst_pc), 32'h06);

    // Redirect wins over stall.
    step(C_BR | C_STALL, 8'h40);
    chk("br_squash", 32'(inst_valid), 32'h0);
    step(C_NONE, 8'h00);
    chk("br_ipc", 32'(inst_pc), 32'h40);
    chk("br_pc", 32'(pc), 32'h41);
    chk("br_inst", 32'(inst), 32'(mem[8'h40]));

    // Back-to-back redirects: only the last target is fetched.
    step(C_BR, 8'h10);
    step(C_BR, 8'h20);
    chk("b2b_valid", 32'(inst_valid), 32'h0);
    step(C_NONE, 8'h00);
    chk("b2b_ipc", 32'(inst_pc), 32'h20);

    // PC wrap-around.
    step(C_BR, 8'hFE);
    step(C_NONE, 8'h00);
    chk("wrap_fe", 32'(inst_pc), 32'hFE);
    step(C_NONE, 8'h00);
    chk("wrap_ff", 32'(inst_pc), 32'hFF);
    chk("wrap_pc", 32'(pc), 32'h00);
    step(C_NONE, 8'h00);
    chk("wrap_00", 32'(inst_pc), 32'h00);
    chk("wrap_valid", 32'(inst_valid), 32'h1);

    // Halt, ignored controls while halted, restart.
    step(C_HALT | C_BR, 8'h77);
    chk("halt_done", 32'(done), 32'h1);
    chk("halt_valid", 32'(inst_valid), 32'h0);
    chk("halt_pc", 32'(pc), 32'h01);
    step(C_BR | C_STALL, 8'h55);
    chk("halted_pc", 32'(pc), 32'h01);
    step(C_START, 8'h00);
    chk("restart_done", 32'(done), 32'h0);
    chk("restart_pc", 32'(pc), 32'(START));

    // Reset mid-fetch beats a redirect.
    step(C_BR, 8'h23);
    chk("mid_pc", 32'(pc), 32'h23);
    step(C_RST | C_BR | C_STALL, 8'h99);
    chk("midrst_pc", 32'(pc), 32'h00);
    chk("midrst_valid", 32'(inst_valid), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    step(C_BR | C_HALT, 8'h44);
    chk("idle_pc", 32'(pc), 32'h00);
    chk("idle_done", 32'(done), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      c[4] = ($urandom_range(99) < 2);
      c[3] = ($urandom_range(99) < 15);
      c[2] = ($urandom_range(99) < 25);
      c[1] = ($urandom_range(99) < 10);
      c[0] = ($urandom_range(99) < 3);
      step(c, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
